// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   General-purpose register bank: one synchronous write port, two registered
//   read ports with write-first forwarding, optional hard-wired zero entry,
//   synchronous clear-all and out-of-range access detection.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset
//   we       in   write enable
//   waddr    in   write address   [ADDR_W]
//   wdata    in   write data      [WIDTH]
//   clear    in   synchronous clear of all entries (wins over a write)
//   re_a     in   read enable, port A
//   raddr_a  in   read address, port A [ADDR_W]
//   rdata_a  out  registered read data, port A [WIDTH]
//   re_b     in   read enable, port B
//   raddr_b  in   read address, port B [ADDR_W]
//   rdata_b  out  registered read data, port B [WIDTH]
//   err      out  one-cycle pulse after any enabled out-of-range access
// -----------------------------------------------------------------------------
module register_file #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 32,
    parameter int               ADDR_W    = 5,
    parameter bit               ZERO_REG  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              clear,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              err
);

    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic             err_q, err_d;
    logic             wr_commit;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L);
    endfunction

    // Value an entry takes on reset or clear; the zero entry stays 0.
    function automatic logic [WIDTH-1:0] init_val(input int idx);
        return (ZERO_REG && idx == 0) ? '0 : RESET_VAL;
    endfunction

    // Value a read loads this edge, seeing the clear/write happening on the
    // same edge (clear first, then write-first forwarding).
    function automatic logic [WIDTH-1:0] read_value(
        input logic [ADDR_W-1:0] ra,
        input logic [WIDTH-1:0]  stored,
        input logic              clr,
        input logic              wc,
        input logic [ADDR_W-1:0] wa,
        input logic [WIDTH-1:0]  wd
    );
        if (!in_range(ra))             return '0;
        if (ZERO_REG && ra == '0)      return '0;
        if (clr)                       return RESET_VAL;
        if (wc && ra == wa)            return wd;
        return stored;
    endfunction

    assign wr_commit = we && in_range(waddr) && !clear && !(ZERO_REG && waddr == '0);

    always_comb begin
        mem_d = mem_q;
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = init_val(i);
        end else if (wr_commit) begin
            mem_d[waddr] = wdata;
        end

        rdata_a_d = rdata_a_q;
        if (re_a) begin
            rdata_a_d = read_value(raddr_a, mem_q[raddr_a], clear, wr_commit, waddr, wdata);
        end

        rdata_b_d = rdata_b_q;
        if (re_b) begin
            rdata_b_d = read_value(raddr_b, mem_q[raddr_b], clear, wr_commit, waddr, wdata);
        end

        // Any number of simultaneous faults collapses to one pulse.
        err_d = (we   && !in_range(waddr))
             || (re_a && !in_range(raddr_a))
             || (re_b && !in_range(raddr_b));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= init_val(i);
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            err_q     <= 1'b0;
        end else begin
            mem_q     <= mem_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            err_q     <= err_d;
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign err     = err_q;

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        we      = 1'b0;
    logic [4:0]  waddr   = '0;
    logic [31:0] wdata   = '0;
    logic        clear   = 1'b0;
    logic        re_a    = 1'b0;
    logic [4:0]  raddr_a = '0;
    logic        re_b    = 1'b0;
    logic [4:0]  raddr_b = '0;

    logic [31:0] rda0, rdb0, rda1, rdb1;
    logic        err0, err1;

    int n_checks = 0;
    int n_fail   = 0;

    // Full-depth instance, RESET_VAL = 0.
    register_file u0 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .clear(clear), .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda0),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb0), .err(err0)
    );

    // Partial-depth instance with non-zero reset value.
    register_file #(.DEPTH(20), .RESET_VAL(32'h0000_005A)) u1 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .clear(clear), .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda1),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb1), .err(err1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; clear = 1'b0; re_a = 1'b0; re_b = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        n_checks++; if (rda0 !== 32'h0) begin n_fail++; $display("FAIL reset_rda0 got %h want %h", rda0, 32'h0); end
        n_checks++; if (rdb0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdb0 got %h want %h", rdb0, 32'h0); end
        n_checks++; if (err0 !== 1'b0)  begin n_fail++; $display("FAIL reset_err0 got %b want 0", err0); end
        n_checks++; if (rda1 !== 32'h0) begin n_fail++; $display("FAIL reset_rda1 got %h want %h", rda1, 32'h0); end
        tick();
        tick();
        reset = 1'b1;
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; re_a = 1'b1; raddr_a = 5'd5;
        tick();
        n_checks++; if (rda0 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pre_reset_read got %h want %h", rda0, 32'hDEAD_BEEF); end
        re_a = 1'b0;
        #3 reset = 1'b0;
        #1;
        n_checks++; if (rda0 !== 32'h0) begin n_fail++; $display("FAIL async_reset_rda0 got %h want %h", rda0, 32'h0); end
        #1 reset = 1'b1;
        re_a = 1'b1; raddr_a = 5'd5;
        tick();
        n_checks++; if (rda0 !== 32'h0) begin n_fail++; $display("FAIL post_reset_entry5_u0 got %h want %h", rda0, 32'h0); end
        n_checks++; if (rda1 !== 32'h5A) begin n_fail++; $display("FAIL post_reset_entry5_u1 got %h want %h", rda1, 32'h5A); end
        idle();
    endtask

    task automatic test_latency();
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
        tick();
        we = 1'b0; re_a = 1'b1; raddr_a = 5'd7;
        tick();
        n_checks++; if (rda0 !== 32'h1234_5678) begin n_fail++; $display("FAIL latency_read got %h want %h", rda0, 32'h1234_5678); end
        re_a = 1'b0; raddr_a = 5'd5;
        tick();
        n_checks++; if (rda0 !== 32'h1234_5678) begin n_fail++; $display("FAIL latency_hold got %h want %h", rda0, 32'h1234_5678); end
        idle();
    endtask

    task automatic test_forwarding();
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5A5_A5A5;
        re_a = 1'b1; raddr_a = 5'd3; re_b = 1'b1; raddr_b = 5'd3;
        tick();
        n_checks++; if (rdb0 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL fwd_rdb0 got %h want %h", rdb0, 32'hA5A5_A5A5); end
        n_checks++; if (rda0 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL fwd_rda0 got %h want %h", rda0, 32'hA5A5_A5A5); end
        n_checks++; if (rda1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL fwd_rda1 got %h want %h", rda1, 32'hA5A5_A5A5); end
        we = 1'b0; raddr_a = 5'd3;
        tick();
        n_checks++; if (rda0 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL fwd_stored got %h want %h", rda0, 32'hA5A5_A5A5); end
        idle();
    endtask

    task automatic test_zero_reg();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        re_a = 1'b1; raddr_a = 5'd0; re_b = 1'b1; raddr_b = 5'd0;
        tick();
        n_checks++; if (rda0 !== 32'h0) begin n_fail++; $display("FAIL zero_same_edge_a got %h want %h", rda0, 32'h0); end
        n_checks++; if (rdb0 !== 32'h0) begin n_fail++; $display("FAIL zero_same_edge_b got %h want %h", rdb0, 32'h0); end
        we = 1'b0;
        tick();
        n_checks++; if (rda0 !== 32'h0) begin n_fail++; $display("FAIL zero_later_a got %h want %h", rda0, 32'h0); end
        n_checks++; if (rdb1 !== 32'h0) begin n_fail++; $display("FAIL zero_later_b_u1 got %h want %h", rdb1, 32'h0); end
        idle();
    endtask

    task automatic test_clear();
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; waddr = i[4:0]; wdata = 32'(i);
            tick();
        end
        we = 1'b0; re_a = 1'b1; raddr_a = 5'd9;
        tick();
        n_checks++; if (rda0 !== 32'd9) begin n_fail++; $display("FAIL fill_u0 got %h want %h", rda0, 32'd9); end
        n_checks++; if (rda1 !== 32'd9) begin n_fail++; $display("FAIL fill_u1 got %h want %h", rda1, 32'd9); end
        clear = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        re_a = 1'b1; raddr_a = 5'd9; re_b = 1'b1; raddr_b = 5'd5;
        tick();
        n_checks++; if (rda0 !== 32'h0)  begin n_fail++; $display("FAIL clear_edge_u0 got %h want %h", rda0, 32'h0); end
        n_checks++; if (rda1 !== 32'h5A) begin n_fail++; $display("FAIL clear_edge_u1a got %h want %h", rda1, 32'h5A); end
        n_checks++; if (rdb1 !== 32'h5A) begin n_fail++; $display("FAIL clear_edge_u1b got %h want %h", rdb1, 32'h5A); end
        clear = 1'b0; we = 1'b0;
        for (int i = 1; i < 20; i++) begin
            raddr_a = i[4:0]; raddr_b = i[4:0];
            tick();
            n_checks++; if (rda1 !== 32'h5A) begin n_fail++; $display("FAIL clear_u1_entry%0d got %h want %h", i, rda1, 32'h5A); end
            n_checks++; if (rdb0 !== 32'h0)  begin n_fail++; $display("FAIL clear_u0_entry%0d got %h want %h", i, rdb0, 32'h0); end
        end
        re_a = 1'b0; raddr_b = 5'd0;
        tick();
        n_checks++; if (rdb1 !== 32'h0) begin n_fail++; $display("FAIL clear_zero_entry got %h want %h", rdb1, 32'h0); end
        idle();
    endtask

    task automatic test_out_of_range();
        // u1 port A currently holds 0x5A from the last clear-loop read.
        we = 1'b1; waddr = 5'd30; wdata = 32'h0000_CAFE;
        re_a = 1'b1; raddr_a = 5'd25; re_b = 1'b0;
        tick();
        n_checks++; if (rda1 !== 32'h0) begin n_fail++; $display("FAIL oor_read_u1 got %h want %h", rda1, 32'h0); end
        n_checks++; if (err1 !== 1'b1)  begin n_fail++; $display("FAIL oor_err_u1 got %b want 1", err1); end
        n_checks++; if (err0 !== 1'b0)  begin n_fail++; $display("FAIL oor_err_u0 got %b want 0", err0); end
        idle();
        tick();
        n_checks++; if (err1 !== 1'b0)  begin n_fail++; $display("FAIL oor_err_drop got %b want 0", err1); end
        re_b = 1'b1;
        for (int i = 1; i < 20; i++) begin
            raddr_b = i[4:0];
            tick();
            n_checks++; if (rdb1 !== 32'h5A) begin n_fail++; $display("FAIL oor_unmodified_entry%0d got %h want %h", i, rdb1, 32'h5A); end
        end
        re_b = 1'b0; re_a = 1'b1; raddr_a = 5'd30;
        tick();
        n_checks++; if (rda0 !== 32'h0000_CAFE) begin n_fail++; $display("FAIL inrange_write_u0 got %h want %h", rda0, 32'h0000_CAFE); end
        n_checks++; if (err1 !== 1'b1) begin n_fail++; $display("FAIL oor_read_only_err got %b want 1", err1); end
        // Out-of-range addresses with enables low must not fault.
        re_a = 1'b0; raddr_a = 5'd25; we = 1'b0; waddr = 5'd30;
        tick();
        n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL oor_disabled_err got %b want 0", err1); end
        we = 1'b1; waddr = 5'd31; wdata = 32'h1;
        re_a = 1'b1; raddr_a = 5'd20; re_b = 1'b1; raddr_b = 5'd21;
        tick();
        n_checks++; if (err1 !== 1'b1) begin n_fail++; $display("FAIL multi_fault_err got %b want 1", err1); end
        idle();
        tick();
        n_checks++; if (err1 !== 1'b0) begin n_fail++; $display("FAIL multi_fault_single_pulse got %b want 0", err1); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_forwarding();
        test_zero_reg();
        test_clear();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
Parametrised multi-port register file built from edge-triggered storage cells. It is the successor to the fixed 32-bit register and serves as the general-purpose register bank of the datapath. It has one synchronous write port and two registered read ports, with write-to-read forwarding. It also provides an optional hard-wired zero register, a synchronous clear-all, and out-of-range address detection.

Parameters:
WIDTH, 32, data width of each entry in bits (1..64)
DEPTH, 32, number of entries (2..2^ADDR_W)
ADDR_W, 5, address width in bits
ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to it are discarded
RESET_VAL, 0, value loaded into every entry on reset or clear (WIDTH bits)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  WIDTH  write data
clear  input  1  synchronous clear of all entries
re_a  input  1  read enable, port A
raddr_a  input  ADDR_W  read address, port A
rdata_a  output  WIDTH  registered read data, port A
re_b  input  1  read enable, port B
raddr_b  input  ADDR_W  read address, port B
rdata_b  output  WIDTH  registered read data, port B
err  output  1  one-cycle pulse on any enabled out-of-range access

Behaviour:
- Reset (reset=0): asynchronous, takes effect immediately, independent of clk.
  - All entries go to RESET_VAL (entry 0 goes to 0 when ZERO_REG=1).
  - rdata_a=0, rdata_b=0, err=0.
  - All state is held at these values while reset=0.
  - Reset asserted mid-write: the write is lost.
- Write commit: at a rising edge, the write commits when all of these hold:
  - we=1
  - waddr<DEPTH
  - clear=0
  - not (ZERO_REG=1 and waddr=0)
- Write timing: a committed value is visible to reads issued from the next edge onward.
- Read latency: 1 cycle.
  - At a rising edge with re_x=1, rdata_x <= entry[raddr_x].
  - With re_x=0, rdata_x holds its previous value.
  - Ports A and B are fully independent and may use the same address.
- Forwarding (write-first): if re_x=1, the write commits on the same edge, and raddr_x=waddr, then rdata_x <= wdata, not the old entry.
- Zero register: with ZERO_REG=1, a read of address 0 always returns 0, even when we=1 and waddr=0 on the same edge.
- Clear:
  - At a rising edge with clear=1, every entry <= RESET_VAL (entry 0 stays 0 if ZERO_REG=1).
  - clear has priority over we; the concurrent write is discarded.
  - An enabled read on the clear edge returns the post-clear value: RESET_VAL, or 0 for entry 0 with ZERO_REG=1.
- Out-of-range (address >= DEPTH, only possible when DEPTH<2^ADDR_W):
  - Write is ignored.
  - Enabled read loads 0 into rdata_x.
  - err <= 1 for exactly one cycle on the edge after the access.
  - Otherwise err <= 0.
  - Accesses with re_x=0 or we=0 never raise err.
  - Multiple simultaneous faults produce a single pulse.
- Width rules: wdata is stored unmodified, with no sign extension. Entries are exactly WIDTH bits.
- No combinational path from any input to rdata_a, rdata_b or err.

Test Plan:
- Reset: write 0xDEADBEEF to entry 5, drop reset between edges -> rdata_a=0 immediately; after release, read entry 5 -> 0x00000000 one cycle later.
- Write/read latency: write 0x12345678 to entry 7 at edge n, re_a=1 raddr_a=7 at edge n+1 -> rdata_a=0x12345678 after edge n+1; with re_a=0 at edge n+2, the value holds.
- Forwarding: same edge we=1 waddr=3 wdata=0xA5A5A5A5 and re_b=1 raddr_b=3 -> rdata_b=0xA5A5A5A5 after that edge; port A reading entry 3 on the same edge also returns 0xA5A5A5A5.
- Zero register: with ZERO_REG=1, write 0xFFFFFFFF to entry 0 while reading entry 0 on both ports -> rdata_a=rdata_b=0 on that edge and all later reads.
- Clear priority: fill entries 1..31 with their index, then assert clear=1 with we=1 waddr=9 wdata=0x99 -> all reads return RESET_VAL (use 0x5A via parameter override); entry 9 is not 0x99.
- Out-of-range: with DEPTH=20 and ADDR_W=5, read address 25 and write address 30 simultaneously -> rdata_a=0, no entry modified, err high for exactly one cycle, then 0.
